lcd_region_seq: RTL
===================

LCD_REGION_SEQ -- requirements
Module: lcd_region_seq

Interface
REQ-001 Parameter COLS, 128, display width in columns (1..256).
REQ-002 Parameter PAGES, 8, display height in 8-pixel pages (1..16).
REQ-003 Parameter PWR_DELAY, 400, clock cycles waited after reset before the first init byte.
REQ-004 clock  in  1  system clock; all state updates on rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 req  in  1  single-cycle region-refresh request.
REQ-007 col_start, col_end  in  8 each  inclusive column window of the request.
REQ-008 page_start, page_end  in  4 each  inclusive page window of the request.
REQ-009 pix_page  out  4, pix_col  out  8  frame-buffer address of the current data byte.
REQ-010 pix_data  in  8  frame-buffer byte, combinationally valid for the current pix_page/pix_col.
REQ-011 byte_out  out  8, byte_dc  out  1 (0 = command, 1 = data), byte_valid  out  1  byte stream to the LCD bus driver.
REQ-012 byte_ready  in  1  bus driver accepts byte_out when byte_valid and byte_ready are both high.
REQ-013 busy  out  1, req_ack  out  1 (pulse), done  out  1 (pulse), ready_init  out  1 (level).

Function
REQ-014 States: PWR_WAIT, INIT, CLEAR, IDLE, SET_PAGE, SET_COL_HI, SET_COL_LO, DATA, DONE.
REQ-015 PWR_WAIT: counts 0..PWR_DELAY-1, byte_valid low, then enters INIT.
REQ-016 INIT: emits the INIT_LEN command bytes of the package init table in order (byte_dc=0), then enters CLEAR.
REQ-017 CLEAR: full-screen refresh of all pages and columns with data byte 0x00 regardless of pix_data; done is not pulsed; afterwards IDLE and ready_init=1.
REQ-018 Handshake: byte_valid, byte_out and byte_dc hold stable until the byte is accepted; the next byte may be presented in the cycle after acceptance; no byte is dropped or duplicated.
REQ-019 IDLE: on req=1, latches the window, pulses req_ack in the following cycle, raises busy, enters SET_PAGE.
REQ-020 Clamping at latch: col_end limited to COLS-1, page_end to PAGES-1; col_start limited to the clamped col_end and page_start to the clamped page_end (an inverted window degenerates to one column or page).
REQ-021 Per page: SET_PAGE emits 0xB0|page, SET_COL_HI emits 0x10|col_start[7:4], SET_COL_LO emits 0x00|col_start[3:0], then DATA emits pix_data (byte_dc=1) for col_start..col_end.
REQ-022 After the last column: next page if page < page_end, otherwise DONE.
REQ-023 DONE: pulses done for one cycle, drops busy, returns to IDLE.
REQ-024 req is ignored (no req_ack) while busy, before ready_init, or in DONE.
REQ-025 pix_page/pix_col equal the page/column of the byte currently presented in DATA; elsewhere they hold their last value.
REQ-026 Column and page counters never wrap past the clamped limits; 8-bit column arithmetic only.

Reset
REQ-027 Reset, including mid-transfer, forces PWR_WAIT with the delay counter at 0; byte_valid=0, busy=1, req_ack=0, done=0, ready_init=0; byte_out=0x00, byte_dc=0, pix_page=0, pix_col=0.
REQ-028 No partially accepted byte is re-sent after reset; the full power-up sequence repeats.

Structure
REQ-029 Package lcd_pkg holds the state enumeration, the command opcodes (0xB0, 0x10, 0x00) and the INIT_LEN / init-table constants.
REQ-030 Sub-module lcd_byte_reg is the single output holding register implementing REQ-018; the FSM and counters stay in lcd_region_seq.

Verification
REQ-031 Reset, byte_ready=1: first byte_valid at cycle PWR_DELAY+1, init table in order, then exactly COLS*PAGES+3*PAGES bytes in CLEAR, ready_init=1.
REQ-032 Window cols 10..12, pages 2..3: stream B2,10,0A,d,d,d,B3,10,0A,d,d,d; done pulses once.
REQ-033 byte_ready toggled randomly during DATA: output sequence identical to REQ-032, byte_out stable while stalled.
REQ-034 col_end=200, page_end=15 with defaults: clamped to 127 and 7; inverted window col_start=50, col_end=20: one column (20) per page.
REQ-035 req during busy and during PWR_WAIT: no req_ack, transfer in progress unaffected.
REQ-036 Reset asserted mid-DATA: byte_valid low the following cycle, PWR_WAIT restarts, full init and CLEAR repeat.

Source files
------------

// File: rtl/lcd_region_seq_pkg.sv
// Shared types and constants for the LCD region refresh sequencer.
// Holds the controller state encoding, command opcodes and the power-up init table.
package lcd_pkg;

    typedef enum logic [3:0] {
        ST_PWR_WAIT,
        ST_INIT,
        ST_CLEAR,
        ST_IDLE,
        ST_SET_PAGE,
        ST_SET_COL_HI,
        ST_SET_COL_LO,
        ST_DATA,
        ST_DONE
    } lcd_state_t;

    localparam logic [7:0] CMD_PAGE   = 8'hB0;
    localparam logic [7:0] CMD_COL_HI = 8'h10;
    localparam logic [7:0] CMD_COL_LO = 8'h00;

    localparam int INIT_LEN = 6;

    // Reset, bias, segment/common direction, power control, display on.
    function automatic logic [7:0] init_byte(input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd0:    b = 8'hE2;
            4'd1:    b = 8'hA2;
            4'd2:    b = 8'hA0;
            4'd3:    b = 8'hC8;
            4'd4:    b = 8'h2F;
            4'd5:    b = 8'hAF;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/lcd_region_seq_if.sv
// Byte stream bus between the region sequencer and the LCD bus driver.
interface lcd_region_seq_if;
    logic [7:0] byte_out;
    logic       byte_dc;
    logic       byte_valid;
    logic       byte_ready;

    modport master (output byte_out, output byte_dc, output byte_valid, input byte_ready);
    modport slave  (input byte_out, input byte_dc, input byte_valid, output byte_ready);
endinterface

// File: rtl/lcd_region_seq_byte_reg.sv
// Single output holding register: a byte stays presented until the driver accepts it.
module lcd_byte_reg (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      i_load,
    input  logic [7:0]                i_byte,
    input  logic                      i_dc,
    lcd_region_seq_if.master          bus,
    output logic                      o_empty,
    output logic                      o_accept
);
    logic       r_valid;
    logic [7:0] r_byte;
    logic       r_dc;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_byte  <= '0;
            r_dc    <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_byte  <= i_byte;
            r_dc    <= i_dc;
        end else if (o_accept) begin
            r_valid <= 1'b0;
        end
    end

    assign o_empty        = !r_valid;
    assign o_accept       = r_valid && bus.byte_ready;
    assign bus.byte_out   = r_byte;
    assign bus.byte_dc    = r_dc;
    assign bus.byte_valid = r_valid;
endmodule

// File: rtl/lcd_region_seq.sv
// Page-addressed LCD controller: power-up wait, init table, full clear, then
// refreshes requested rectangular windows from an external frame buffer.
module lcd_region_seq
    import lcd_pkg::*;
#(
    parameter int COLS      = 128,
    parameter int PAGES     = 8,
    parameter int PWR_DELAY = 400
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic [7:0]        col_start,
    input  logic [7:0]        col_end,
    input  logic [3:0]        page_start,
    input  logic [3:0]        page_end,
    output logic [3:0]        pix_page,
    output logic [7:0]        pix_col,
    input  logic [7:0]        pix_data,
    lcd_region_seq_if.master  bus,
    output logic              busy,
    output logic              req_ack,
    output logic              done,
    output logic              ready_init
);
    localparam int         PCW       = (PWR_DELAY > 1) ? $clog2(PWR_DELAY) : 1;
    localparam logic [PCW-1:0] PWR_LAST = PCW'(PWR_DELAY - 1);
    localparam logic [7:0] COL_MAX   = 8'(COLS - 1);
    localparam logic [3:0] PAGE_MAX  = 4'(PAGES - 1);

    lcd_state_t     r_state, w_state_n;
    logic [PCW-1:0] r_pwr_cnt;
    logic [3:0]     r_init_idx;
    logic           r_clear;
    logic [7:0]     r_cs, r_ce, r_pix_col;
    logic [3:0]     r_page, r_pe, r_pix_page;
    logic           r_req_ack, r_ready_init;

    logic           w_load, w_dc, w_empty, w_accept;
    logic [7:0]     w_byte, w_ce, w_cs;
    logic [3:0]     w_pe, w_ps;

    // End limits clamp first so an inverted window collapses onto its end.
    assign w_ce = (col_end > COL_MAX) ? COL_MAX : col_end;
    assign w_cs = (col_start > w_ce) ? w_ce : col_start;
    assign w_pe = (page_end > PAGE_MAX) ? PAGE_MAX : page_end;
    assign w_ps = (page_start > w_pe) ? w_pe : page_start;

    lcd_byte_reg u_byte_reg (
        .clock    (clock),
        .reset    (reset),
        .i_load   (w_load),
        .i_byte   (w_byte),
        .i_dc     (w_dc),
        .bus      (bus),
        .o_empty  (w_empty),
        .o_accept (w_accept)
    );

    always_comb begin
        w_state_n = r_state;
        w_load    = 1'b0;
        w_byte    = '0;
        w_dc      = 1'b0;
        case (r_state)
            ST_PWR_WAIT: if (r_pwr_cnt == PWR_LAST) w_state_n = ST_INIT;
            ST_INIT: begin
                w_byte = init_byte(r_init_idx);
                w_load = w_empty;
                if (w_accept && r_init_idx == 4'(INIT_LEN - 1)) w_state_n = ST_CLEAR;
            end
            ST_CLEAR: w_state_n = ST_SET_PAGE;
            ST_IDLE:  if (req) w_state_n = ST_SET_PAGE;
            ST_SET_PAGE: begin
                w_byte = CMD_PAGE | {4'h0, r_page};
                w_load = w_empty;
                if (w_accept) w_state_n = ST_SET_COL_HI;
            end
            ST_SET_COL_HI: begin
                w_byte = CMD_COL_HI | {4'h0, r_cs[7:4]};
                w_load = w_empty;
                if (w_accept) w_state_n = ST_SET_COL_LO;
            end
            ST_SET_COL_LO: begin
                w_byte = CMD_COL_LO | {4'h0, r_cs[3:0]};
                w_load = w_empty;
                if (w_accept) w_state_n = ST_DATA;
            end
            ST_DATA: begin
                w_byte = r_clear ? 8'h00 : pix_data;
                w_dc   = 1'b1;
                w_load = w_empty;
                if (w_accept && r_pix_col == r_ce) begin
                    if (r_page != r_pe) w_state_n = ST_SET_PAGE;
                    else                w_state_n = r_clear ? ST_IDLE : ST_DONE;
                end
            end
            ST_DONE: w_state_n = ST_IDLE;
            default: w_state_n = ST_PWR_WAIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_PWR_WAIT;
            r_pwr_cnt    <= '0;
            r_init_idx   <= '0;
            r_clear      <= 1'b0;
            r_cs         <= '0;
            r_ce         <= '0;
            r_page       <= '0;
            r_pe         <= '0;
            r_pix_col    <= '0;
            r_pix_page   <= '0;
            r_req_ack    <= 1'b0;
            r_ready_init <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_req_ack <= (r_state == ST_IDLE) && req;
            case (r_state)
                ST_PWR_WAIT: if (r_pwr_cnt != PWR_LAST) r_pwr_cnt <= r_pwr_cnt + 1'b1;
                ST_INIT:     if (w_accept) r_init_idx <= r_init_idx + 1'b1;
                ST_CLEAR: begin
                    r_clear <= 1'b1;
                    r_cs    <= '0;
                    r_ce    <= COL_MAX;
                    r_page  <= '0;
                    r_pe    <= PAGE_MAX;
                end
                ST_IDLE: if (req) begin
                    r_clear <= 1'b0;
                    r_cs    <= w_cs;
                    r_ce    <= w_ce;
                    r_page  <= w_ps;
                    r_pe    <= w_pe;
                end
                // Frame-buffer address moves only when entering or stepping through DATA,
                // so it always names the byte being fetched or presented.
                ST_SET_COL_LO: if (w_accept) begin
                    r_pix_col  <= r_cs;
                    r_pix_page <= r_page;
                end
                ST_DATA: if (w_accept) begin
                    if (r_pix_col != r_ce)    r_pix_col <= r_pix_col + 1'b1;
                    else if (r_page != r_pe)  r_page    <= r_page + 1'b1;
                    else if (r_clear)         r_ready_init <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy       = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done       = (r_state == ST_DONE);
    assign req_ack    = r_req_ack;
    assign ready_init = r_ready_init;
    assign pix_page   = r_pix_page;
    assign pix_col    = r_pix_col;
endmodule
